alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command sequencer between the UART receiver/transmitter pair and the combinational ALU. Parses tagged byte pairs from UART RX into operand A, operand B and opcode registers, fires the ALU once per opcode, captures the result and transmits a two-byte response (header + result) through UART TX with a strict start/done handshake. Replaces ad-hoc parsing with a single FSM that owns the ALU inputs and arbitrates the TX channel.

## Interface
- NB_DATA, 8, data/operand byte width
- NB_OP, 6, ALU opcode width (low bits of the opcode value byte)
- NB_TIMEOUT, 16, timeout counter width
- TIMEOUT_CYCLES, 50000, max cycles between tag byte and value byte
- clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_rx_data  in  NB_DATA  received byte, valid while i_rx_done=1
- i_rx_done  in  1  one-cycle pulse per received byte
- i_tx_done  in  1  one-cycle pulse when TX finished a byte
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data
- o_tx_data  out  NB_DATA  byte to transmit, stable from o_tx_start until i_tx_done
- o_datoA, o_datoB  out  NB_DATA  registered ALU operands
- o_operation  out  NB_OP  registered ALU opcode
- o_valid  out  1  one-cycle ALU execute strobe
- i_result  in  NB_DATA  ALU result (combinational from outputs above)
- o_busy  out  1  high in any state except IDLE
- o_overrun  out  1  sticky: RX byte dropped because sequencer was busy
- o_timeout  out  1  one-cycle pulse on value-byte timeout

## Operation
- Frame = tag byte, then value byte. Tags: 0x08 → operand A, 0x10 → operand B, 0x20 → opcode (value[NB_OP-1:0]).
- States: IDLE → WAIT_VAL → (A/B: back to IDLE) | (OP: EXEC → CAPT → TX_HDR → TX_RES → IDLE); unknown tag: IDLE → TX_NAK → IDLE.
- IDLE: on i_rx_done latch tag; known tag → WAIT_VAL; unknown tag → TX_NAK.
- WAIT_VAL: on i_rx_done write value into register selected by tag; A/B → IDLE; OP → EXEC.
- EXEC: o_valid=1 for exactly one cycle; → CAPT.
- CAPT: register i_result into result buffer; → TX_HDR.
- TX_HDR: pulse o_tx_start with o_tx_data=0xA5 on entry, hold data, wait i_tx_done → TX_RES.
- TX_RES: pulse o_tx_start with captured result, wait i_tx_done → IDLE.
- TX_NAK: pulse o_tx_start with 0x15, wait i_tx_done → IDLE.
- Operands/opcode hold their value until overwritten; no clear after execution.
- i_rx_done in any state other than IDLE/WAIT_VAL: byte discarded, o_overrun set (sticky until reset).
- i_tx_done outside TX states: ignored.
- Simultaneous i_rx_done and i_tx_done in a TX state: TX advances, RX byte dropped with overrun.

## Timing
- Reset: state IDLE; all outputs 0 (o_tx_data, operands, opcode, o_valid, o_tx_start, o_busy, o_overrun, o_timeout); result buffer 0; counter 0.
- Reset mid-transfer: immediate abort, o_tx_start low asynchronously; no resumption.
- Opcode value byte at cycle N (i_rx_done) → o_valid at N+2 → result captured N+3 → first o_tx_start N+4.
- Each o_tx_start is one cycle, issued the cycle after state entry; next start no earlier than the cycle after i_tx_done.
- ALU treated as combinational: i_result sampled one cycle after o_valid.
- A/B value byte at cycle N → register updated, visible at N+1; o_busy low at N+1.

## Configuration
- ALU_SEQ_TIMEOUT_EN defined: counter cleared on WAIT_VAL entry, increments each cycle in WAIT_VAL; on reaching TIMEOUT_CYCLES-1 without i_rx_done → IDLE, pending tag discarded, o_timeout pulses one cycle. i_rx_done on the terminal cycle wins (value accepted, no timeout).
- Not defined: WAIT_VAL waits indefinitely; counter not instantiated; o_timeout tied 0.

## Structure
- Shared package alu_uart_pkg: tag constants (0x08/0x10/0x20), response codes (0xA5 header, 0x15 NAK), state enum encoding.
- One sub-module: seq_timeout_counter (clear, enable, terminal-count pulse), instantiated only under ALU_SEQ_TIMEOUT_EN.

## Test plan
- Bytes 0x08,0x05,0x10,0x03,0x20,0x20 (ADD) with ALU model → o_valid once, TX bytes 0xA5 then 0x08, o_datoA=0x05, o_datoB=0x03.
- Tag 0x7F → single TX byte 0x15, registers unchanged, back to IDLE.
- Byte 0x08 during TX_HDR wait → dropped, o_overrun=1 and stays 1; response still 0xA5,result.
- With ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16: tag 0x10, no value for 16 cycles → o_timeout pulse, o_datoB unchanged, next 0x10,0x09 accepted.
- Assert i_rst_n=0 while waiting i_tx_done after header → all outputs 0, state IDLE; new full frame completes normally.
- i_tx_done held off 100 cycles → o_tx_data stable, no second o_tx_start until done.

Source files
------------

// File: rtl/alu_uart_pkg.sv
// Shared constants and state encoding for the ALU command sequencer:
// frame tags, response codes and the sequencer state enum.
package alu_uart_pkg;

  localparam logic [7:0] TAG_A    = 8'h08;
  localparam logic [7:0] TAG_B    = 8'h10;
  localparam logic [7:0] TAG_OP   = 8'h20;
  localparam logic [7:0] RESP_HDR = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_VAL = 3'd1,
    ST_EXEC     = 3'd2,
    ST_CAPT     = 3'd3,
    ST_TX_HDR   = 3'd4,
    ST_TX_RES   = 3'd5,
    ST_TX_NAK   = 3'd6
  } seq_state_e;

  function automatic logic is_known_tag(input logic [7:0] tag);
    return (tag == TAG_A) || (tag == TAG_B) || (tag == TAG_OP);
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Value-byte timeout counter: cleared on entry to the wait state, counts
// while enabled, raises o_tc while it sits at TIMEOUT_CYCLES-1. Saturates
// at the terminal value so a late enable never wraps.
module seq_timeout_counter #(
  parameter int NB_TIMEOUT     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [NB_TIMEOUT-1:0] TC_VALUE = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] cnt_q;
  logic [NB_TIMEOUT-1:0] cnt_d;

  // Next count: clear has priority, then count up to the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != TC_VALUE)) begin
      cnt_d = cnt_q + NB_TIMEOUT'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc = i_en && (cnt_q == TC_VALUE);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer between UART RX/TX and a combinational ALU.
// Parses (tag, value) byte pairs, fires the ALU on an opcode, and sends a
// header + result response (or a NAK for an unknown tag).
// Optional build macro: ALU_SEQ_TIMEOUT_EN adds a value-byte timeout.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | waiting for a tag byte
// ST_WAIT_VAL | tag latched, waiting for its value byte
// ST_EXEC     | operands/opcode stable, o_valid strobes next cycle
// ST_CAPT     | ALU result registered into the result buffer
// ST_TX_HDR   | sending 0xA5 header, waiting for i_tx_done
// ST_TX_RES   | sending captured result, waiting for i_tx_done
// ST_TX_NAK   | sending 0x15 for an unknown tag, waiting for i_tx_done
module alu_cmd_sequencer
  import alu_uart_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int NB_TIMEOUT     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_operation,
  output logic               o_valid,
  input  logic [NB_DATA-1:0] i_result,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_timeout
);

  seq_state_e         state_q, state_d;
  logic [NB_DATA-1:0] tag_q, tag_d;
  logic [NB_DATA-1:0] dato_a_q, dato_a_d;
  logic [NB_DATA-1:0] dato_b_q, dato_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               tx_sent_q, tx_sent_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               timeout_tc;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic wait_entry;
  logic timeout_q, timeout_d;

  assign wait_entry = (state_d == ST_WAIT_VAL) && (state_q != ST_WAIT_VAL);

  seq_timeout_counter #(
    .NB_TIMEOUT     (NB_TIMEOUT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (wait_entry),
    .i_en    (state_q == ST_WAIT_VAL),
    .o_tc    (timeout_tc)
  );

  // A value byte arriving on the terminal cycle wins over the timeout.
  assign timeout_d = timeout_tc && !i_rx_done;

  // One-cycle timeout pulse register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign timeout_tc         = 1'b0;
  assign o_timeout          = 1'b0;
  assign unused_timeout_cfg = ^{32'(NB_TIMEOUT), 32'(TIMEOUT_CYCLES)};
`endif

  // Next-state and datapath updates; every TX byte goes out the cycle
  // after its state is entered and the state waits for i_tx_done.
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    dato_a_d   = dato_a_q;
    dato_b_d   = dato_b_q;
    op_d       = op_q;
    result_d   = result_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    tx_sent_d  = tx_sent_q;
    valid_d    = 1'b0;
    overrun_d  = overrun_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          tag_d   = i_rx_data;
          state_d = is_known_tag(i_rx_data) ? ST_WAIT_VAL : ST_TX_NAK;
        end
      end
      ST_WAIT_VAL: begin
        if (i_rx_done) begin
          state_d = ST_IDLE;
          if (tag_q == TAG_A) begin
            dato_a_d = i_rx_data;
          end else if (tag_q == TAG_B) begin
            dato_b_d = i_rx_data;
          end else if (tag_q == TAG_OP) begin
            op_d    = i_rx_data[NB_OP-1:0];
            state_d = ST_EXEC;
          end
        end else if (timeout_tc) begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        valid_d = 1'b1;
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        result_d  = i_result;
        tx_sent_d = 1'b0;
        state_d   = ST_TX_HDR;
      end
      ST_TX_HDR, ST_TX_RES, ST_TX_NAK: begin
        if (!tx_sent_q) begin
          tx_start_d = 1'b1;
          tx_sent_d  = 1'b1;
          if (state_q == ST_TX_HDR) begin
            tx_data_d = RESP_HDR;
          end else if (state_q == ST_TX_RES) begin
            tx_data_d = result_q;
          end else begin
            tx_data_d = RESP_NAK;
          end
        end else if (i_tx_done) begin
          tx_sent_d = 1'b0;
          state_d   = (state_q == ST_TX_HDR) ? ST_TX_RES : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (i_rx_done && (state_q != ST_IDLE) && (state_q != ST_WAIT_VAL)) begin
      overrun_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      tag_q      <= '0;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      op_q       <= '0;
      result_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      tx_sent_q  <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      dato_a_q   <= dato_a_d;
      dato_b_q   <= dato_b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      tx_sent_q  <= tx_sent_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_tx_start  = tx_start_q;
  assign o_tx_data   = tx_data_q;
  assign o_datoA     = dato_a_q;
  assign o_datoB     = dato_b_q;
  assign o_operation = op_q;
  assign o_valid     = valid_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: transaction-level model of the
// byte protocol, per-cycle compare, directed frames plus random traffic.
module tb_alu_cmd_sequencer;

  localparam int TB_TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       resp_done = 1'b0;
  logic       stray_done = 1'b0;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] dato_a, dato_b;
  logic [5:0] operation;
  logic       valid;
  logic [7:0] result;
  logic       busy, overrun, timeout;

  always #5 clk = ~clk;

  assign tx_done = resp_done | stray_done;

  alu_cmd_sequencer #(
    .NB_DATA(8), .NB_OP(6), .NB_TIMEOUT(16), .TIMEOUT_CYCLES(TB_TO)
  ) dut (
    .clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .o_datoA(dato_a), .o_datoB(dato_b), .o_operation(operation),
    .o_valid(valid), .i_result(result), .o_busy(busy),
    .o_overrun(overrun), .o_timeout(timeout)
  );

  // Reference ALU (MIPS-style opcodes)
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                     input logic [5:0] op);
    case (op)
      6'h20:   return 8'(a + b);
      6'h22:   return 8'(a - b);
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b);
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  assign result = alu(dato_a, dato_b, operation);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         cyc = 0;
  int         exp_valid_cyc, exp_start_cyc, exp_timeout_cyc, m_deadline;
  logic [7:0] m_a, m_b, m_tag, m_cur;
  logic [5:0] m_op;
  bit         m_pending, m_resp_active, m_outstanding, m_overrun;
  logic [7:0] m_q[$];
  logic [7:0] tx_log[$];
  int         n_valid = 0;
  int         n_timeout = 0;

  function automatic void model_reset();
    exp_valid_cyc = -1; exp_start_cyc = -1; exp_timeout_cyc = -1; m_deadline = -1;
    m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tag = 8'h00; m_cur = 8'h00;
    m_pending = 0; m_resp_active = 0; m_outstanding = 0; m_overrun = 0;
    m_q.delete();
  endfunction

  function automatic bit known(input logic [7:0] t);
    return (t == 8'h08) || (t == 8'h10) || (t == 8'h20);
  endfunction

  // Compare current outputs with the model, then advance the model with
  // the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      chk("busy", busy, m_pending || m_resp_active);
      chk("valid", valid, cyc == exp_valid_cyc);
      chk("tx_start", tx_start, cyc == exp_start_cyc);
      chk("timeout", timeout, cyc == exp_timeout_cyc);
      chk("overrun", overrun, m_overrun);
      chk("datoA", dato_a, m_a);
      chk("datoB", dato_b, m_b);
      chk("operation", operation, m_op);
      if (m_outstanding) chk("tx_data_hold", tx_data, m_cur);
      if (valid) n_valid++;
      if (timeout) n_timeout++;
      if (tx_start && !m_outstanding && m_q.size() > 0) begin
        chk("tx_data", tx_data, m_q[0]);
        m_cur = m_q[0];
        m_outstanding = 1;
        tx_log.push_back(tx_data);
      end

      if (rx_done) begin
        if (m_resp_active) begin
          m_overrun = 1;
        end else if (m_pending) begin
          m_pending = 0;
          if (m_tag == 8'h08) m_a = rx_data;
          else if (m_tag == 8'h10) m_b = rx_data;
          else begin
            m_op = rx_data[5:0];
            m_resp_active = 1;
            exp_valid_cyc = cyc + 2;
            exp_start_cyc = cyc + 4;
            m_q.push_back(8'hA5);
            m_q.push_back(alu(m_a, m_b, m_op));
          end
        end else if (known(rx_data)) begin
          m_pending  = 1;
          m_tag      = rx_data;
          m_deadline = cyc + TB_TO;
        end else begin
          m_resp_active = 1;
          exp_start_cyc = cyc + 2;
          m_q.push_back(8'h15);
        end
      end
`ifdef ALU_SEQ_TIMEOUT_EN
      else if (m_pending && cyc == m_deadline) begin
        m_pending = 0;
        exp_timeout_cyc = cyc + 1;
      end
`endif

      if (tx_done && m_outstanding) begin
        void'(m_q.pop_front());
        m_outstanding = 0;
        if (m_q.size() > 0) exp_start_cyc = cyc + 2;
        else m_resp_active = 0;
      end
    end
  end

  // ---------------- UART TX responder ----------------
  int hold_cyc = 0;
  bit resp_idle = 1;
  int resp_d;

  always begin
    @(negedge clk);
    if (tx_start && rst_n) begin
      resp_idle = 0;
      resp_d = (hold_cyc > 0) ? hold_cyc : int'($urandom_range(1, 6));
      repeat (resp_d) @(posedge clk);
      #1 resp_done = 1'b1;
      @(posedge clk);
      #1 resp_done = 1'b0;
      resp_idle = 1;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(8'h08); send_byte(a);
    send_byte(8'h10); send_byte(b);
    send_byte(8'h20); send_byte(op);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((m_pending || m_resp_active || !resp_idle) && n < bound) begin
      tick();
      n++;
    end
    chk("idle_reached", n < bound, 1);
  endtask

  task automatic wait_hdr(input int bound);
    int n = 0;
    while (!(m_outstanding && m_q.size() == 2) && n < bound) begin
      tick();
      n++;
    end
    chk("hdr_reached", n < bound, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_datoA"}, dato_a, 0);
    chk({tag, "_datoB"}, dato_b, 0);
    chk({tag, "_operation"}, operation, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    int r;
    int g;
    int gmax;
    logic [7:0] b;
    logic [7:0] t;

`ifdef ALU_SEQ_TIMEOUT_EN
    gmax = 20;
`else
    gmax = 3;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Basic ADD frame: 5 + 3
    tx_log.delete();
    v0 = n_valid;
    send_frame(8'h05, 8'h03, 8'h20);
    wait_idle(400);
    chk("add_valid_count", n_valid - v0, 1);
    chk("add_log_size", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      chk("add_hdr", tx_log[0], 8'hA5);
      chk("add_res", tx_log[1], 8'h08);
    end
    chk("add_datoA", dato_a, 8'h05);
    chk("add_datoB", dato_b, 8'h03);

    // Unknown tag -> NAK only
    tx_log.delete();
    send_byte(8'h7F);
    wait_idle(400);
    chk("nak_log_size", tx_log.size(), 1);
    if (tx_log.size() == 1) chk("nak_byte", tx_log[0], 8'h15);
    chk("nak_datoA", dato_a, 8'h05);
    chk("nak_datoB", dato_b, 8'h03);
    chk("nak_busy", busy, 0);

    // Byte during header wait -> overrun, response intact (1 - 2 = 0xFF)
    tx_log.delete();
    hold_cyc = 10;
    send_frame(8'h01, 8'h02, 8'h22);
    wait_hdr(60);
    rx_data = 8'h08; rx_done = 1'b1; tick(); rx_done = 1'b0;
    wait_idle(400);
    hold_cyc = 0;
    chk("ovr_flag", overrun, 1);
    chk("ovr_log_size", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      chk("ovr_hdr", tx_log[0], 8'hA5);
      chk("ovr_res", tx_log[1], 8'hFF);
    end

    // Long TX hold-off: data stable, no extra start (0x0C | 0x30 = 0x3C)
    tx_log.delete();
    hold_cyc = 100;
    send_frame(8'h0C, 8'h30, 8'h25);
    wait_idle(400);
    hold_cyc = 0;
    chk("hold_log_size", tx_log.size(), 2);
    if (tx_log.size() == 2) chk("hold_res", tx_log[1], 8'h3C);
    chk("hold_overrun_sticky", overrun, 1);

    // Reset while waiting for header done
    hold_cyc = 100;
    send_frame(8'h0A, 8'h0B, 8'h26);
    wait_hdr(60);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    hold_cyc = 0;
    wait_idle(400);
    tx_log.delete();
    send_frame(8'h07, 8'h02, 8'h20);
    wait_idle(400);
    chk("postrst_log_size", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      chk("postrst_hdr", tx_log[0], 8'hA5);
      chk("postrst_res", tx_log[1], 8'h09);
    end
    chk("postrst_overrun", overrun, 0);

`ifdef ALU_SEQ_TIMEOUT_EN
    // Tag B with no value -> one timeout pulse, B unchanged
    v0 = n_timeout;
    send_byte(8'h10);
    repeat (20) tick();
    chk("to_pulses", n_timeout - v0, 1);
    chk("to_datoB", dato_b, 8'h02);
    chk("to_busy", busy, 0);
    send_byte(8'h10); send_byte(8'h09);
    wait_idle(400);
    chk("to_next_datoB", dato_b, 8'h09);
`endif

    // Random traffic
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      g = $urandom_range(0, gmax);
      if (r <= 2) begin
        send_byte(($urandom_range(0, 1) == 1) ? 8'h08 : 8'h10);
        repeat (g) tick();
        send_byte(8'($urandom));
      end else if (r <= 6 || r == 8) begin
        b = 8'($urandom);
        if ($urandom_range(0, 3) != 0) b[5:0] = ops[$urandom_range(0, 7)];
        send_byte(8'h20);
        repeat (g) tick();
        send_byte(b);
        if (r == 8) begin
          repeat ($urandom_range(0, 5)) tick();
          if (m_resp_active) begin
            rx_data = 8'($urandom); rx_done = 1'b1; tick(); rx_done = 1'b0;
          end
        end
      end else if (r == 7) begin
        t = 8'($urandom);
        while (known(t)) t = 8'($urandom);
        send_byte(t);
      end else begin
        stray_done = 1'b1; tick(); stray_done = 1'b0; tick();
      end
      wait_idle(400);
    end

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
